// File: rtl/reg_display_scan.sv
// reg_display_scan: walks the CPU register-select through all 32 registers and
// shows the selected value as 8 hex digits on a multiplexed, active-low
// 7-segment display. One register value is captured per display frame.
//
// Parameters:
//   SCAN_DIV  clk cycles per digit slot (>= 2)
//   STEP_DIV  clk cycles per register advance (>= 2)
// Ports:
//   clk       system clock (shared with the CPU)
//   rst       asynchronous, active-high reset
//   pause     holds reg_sel while high; lights the dp on digit 7
//   reg_data  register value for the current reg_sel (combinational from CPU)
//   reg_sel   register index presented to the CPU (registered)
//   an        digit enables, active-low, one-hot
//   seg       segments, active-low; seg[6:0] = g..a, seg[7] = decimal point
// Build option:
//   REGDISP_BLANK_EN  when defined, leading zero digits (other than digit 0)
//                     are blanked.
module reg_display_scan #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned STEP_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam int unsigned STEP_W = $clog2(STEP_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [2:0]        digit;
  logic [31:0]       disp_val;

  logic              scan_tick_c;
  logic              step_tick_c;
  logic [3:0]        nibble_c;
  logic [7:0]        hex_c;
  logic              blank_c;
  logic [7:0]        an_c;
  logic [7:0]        seg_c;

  assign scan_tick_c = (scan_cnt == SCAN_LAST);
  assign step_tick_c = (step_cnt == STEP_LAST);
  assign nibble_c    = disp_val[{digit, 2'b00} +: 4];

  // Hex to active-low segments, dp off.
  always_comb begin
    hex_c = 8'hFF;
    case (nibble_c)
      4'h0: hex_c = 8'hC0;
      4'h1: hex_c = 8'hF9;
      4'h2: hex_c = 8'hA4;
      4'h3: hex_c = 8'hB0;
      4'h4: hex_c = 8'h99;
      4'h5: hex_c = 8'h92;
      4'h6: hex_c = 8'h82;
      4'h7: hex_c = 8'hF8;
      4'h8: hex_c = 8'h80;
      4'h9: hex_c = 8'h90;
      4'hA: hex_c = 8'h88;
      4'hB: hex_c = 8'h83;
      4'hC: hex_c = 8'hC6;
      4'hD: hex_c = 8'hA1;
      4'hE: hex_c = 8'h86;
      default: hex_c = 8'h8E;
    endcase
  end

  // A digit is a leading zero when every nibble from it upward is zero.
`ifdef REGDISP_BLANK_EN
  assign blank_c = (digit != 3'd0) && ((disp_val >> {digit, 2'b00}) == 32'd0);
`else
  assign blank_c = 1'b0;
`endif

  // Next display drive from the current digit index and captured value.
  always_comb begin
    an_c       = ~(8'b0000_0001 << digit);
    seg_c      = 8'hFF;
    seg_c[6:0] = blank_c ? 7'h7F : hex_c[6:0];
    seg_c[7]   = ~(pause && (digit == 3'd7));
  end

  // Scan and step counters, frame snapshot, registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      step_cnt <= '0;
      digit    <= 3'd0;
      disp_val <= 32'd0;
      reg_sel  <= 5'd0;
      an       <= 8'hFF;
      seg      <= 8'hFF;
    end else begin
      an  <= an_c;
      seg <= seg_c;

      if (scan_tick_c) begin
        scan_cnt <= '0;
        digit    <= digit + 3'd1;
        // Capture on the 7->0 wrap so each frame shows one register value;
        // reg_data still reflects the pre-edge reg_sel here.
        if (digit == 3'd7) begin
          disp_val <= reg_data;
        end
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      // The step counter free-runs; pause only gates the increment.
      if (step_tick_c) begin
        step_cnt <= '0;
        if (!pause) begin
          reg_sel <= reg_sel + 5'd1;
        end
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

endmodule
